// File: rtl/sevenseg_capture.sv
// Seven-segment bus capture: synchronizes digit strobe and segment lines,
// decodes each settled digit to hex and delivers whole frames on valid/ready.
module sevenseg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    overrun
);

    localparam int SW = NUM_DIGITS + 7;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [6:0]              seg_m_q, seg_m_d, seg_s_q, seg_s_d;
    logic [NUM_DIGITS-1:0]   dig_m_q, dig_m_d, dig_s_q, dig_s_d;
    logic [SW-1:0]           prev_q, prev_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    armed_q, armed_d;
    logic [4*NUM_DIGITS-1:0] stage_q, stage_d;
    logic [NUM_DIGITS-1:0]   stage_err_q, stage_err_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    valid_q, valid_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    overrun_q, overrun_d;

    logic [SW-1:0] samp;
    logic          stable;
    logic          onehot;
    logic          capture;
    logic          frame_full;
    logic [4:0]    dec;

    // Returns {error, value}; unknown patterns read as 0 with error set.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0111111: decode = 5'h00;
            7'b0000110: decode = 5'h01;
            7'b1011011: decode = 5'h02;
            7'b1001111: decode = 5'h03;
            7'b1100110: decode = 5'h04;
            7'b1101101: decode = 5'h05;
            7'b1111101: decode = 5'h06;
            7'b0000111: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1101111: decode = 5'h09;
            7'b1110111: decode = 5'h0a;
            7'b1111100: decode = 5'h0b;
            7'b0111001: decode = 5'h0c;
            7'b1011110: decode = 5'h0d;
            7'b1111001: decode = 5'h0e;
            7'b1110001: decode = 5'h0f;
            default:    decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        seg_m_d = seg_in;
        seg_s_d = seg_m_q;
        dig_m_d = dig_sel;
        dig_s_d = dig_m_q;

        samp   = {dig_s_q, seg_s_q};
        stable = (samp == prev_q);
        onehot = (dig_s_q != '0) &&
                 ((dig_s_q & (dig_s_q - NUM_DIGITS'(1))) == '0);
        prev_d = samp;

        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (!stable) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        // One capture per strobe period: armed is re-set only by a change.
        capture = stable && (cnt_d == CNT_MAX) && armed_q && onehot;
        if (capture) begin
            armed_d = 1'b0;
        end

        dec         = decode(seg_s_q);
        frame_full  = &mask_q;
        stage_d     = stage_q;
        stage_err_d = stage_err_q;
        mask_d      = frame_full ? '0 : mask_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && dig_s_q[i]) begin
                stage_d[4*i +: 4] = dec[3:0];
                stage_err_d[i]    = dec[4];
                mask_d[i]         = 1'b1;
            end
        end

        valid_d   = valid_q;
        digits_d  = digits_q;
        err_d     = err_q;
        overrun_d = 1'b0;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (frame_full) begin
            if (!valid_q || out_ready) begin
                valid_d  = 1'b1;
                digits_d = stage_q;
                err_d    = stage_err_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m_q     <= '0;
            seg_s_q     <= '0;
            dig_m_q     <= '0;
            dig_s_q     <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            stage_q     <= '0;
            stage_err_q <= '0;
            mask_q      <= '0;
            valid_q     <= 1'b0;
            digits_q    <= '0;
            err_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            seg_m_q     <= seg_m_d;
            seg_s_q     <= seg_s_d;
            dig_m_q     <= dig_m_d;
            dig_s_q     <= dig_s_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            stage_q     <= stage_d;
            stage_err_q <= stage_err_d;
            mask_q      <= mask_d;
            valid_q     <= valid_d;
            digits_q    <= digits_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = valid_q;
    assign digits    = digits_q;
    assign digit_err = err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: sweeps, decode table, settling,
// strobe validity, overrun/backpressure and mid-frame reset.
module tb_sevenseg_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    int          acc_cnt = 0;
    logic [15:0] acc_dig = '0;
    logic [3:0]  acc_err = '0;
    int          ov_cnt  = 0;

    logic [6:0] pat [16];

    sevenseg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .digits    (digits),
        .digit_err (digit_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Record every accepted frame and every overrun pulse
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_dig <= digits;
            acc_err <= digit_err;
        end
        if (overrun) ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [3:0] d, input logic [6:0] s, input int n);
        dig_sel = d;
        seg_in  = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        pat = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        rst = 1'b1;
        seg_in = '0;
        dig_sel = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_err", 32'(digit_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_mask", 32'(dut.mask_q), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic sweep 1,2,3,4
        put(4'b0001, pat[1], 10);
        put(4'b0010, pat[2], 10);
        put(4'b0100, pat[3], 10);
        put(4'b1000, pat[4], 10);
        put(4'b0000, 7'h00, 10);
        check("sweep_cnt", 32'(acc_cnt), 32'd1);
        check("sweep_dig", 32'(acc_dig), 32'h4321);
        check("sweep_err", 32'(acc_err), 32'd0);
        check("sweep_valid_low", 32'(out_valid), 32'd0);

        // Whole decode table, four frames
        for (int f = 0; f < 4; f++) begin
            put(4'b0001, pat[4*f], 10);
            put(4'b0010, pat[4*f+1], 10);
            put(4'b0100, pat[4*f+2], 10);
            put(4'b1000, pat[4*f+3], 10);
            put(4'b0000, 7'h00, 10);
            check("table_cnt", 32'(acc_cnt), 32'(2 + f));
            check("table_dig", 32'(acc_dig), 32'h3210 + 32'(f) * 32'h4444);
            check("table_err", 32'(acc_err), 32'd0);
        end

        // Unrecognized and blank patterns
        put(4'b0001, 7'b1010101, 10);
        put(4'b0010, pat[1], 10);
        put(4'b0100, 7'b0000000, 10);
        put(4'b1000, pat[3], 10);
        put(4'b0000, 7'h00, 10);
        check("bad_cnt", 32'(acc_cnt), 32'd6);
        check("bad_dig", 32'(acc_dig), 32'h3010);
        check("bad_err", 32'(acc_err), 32'b0101);

        // Input never settles long enough, then holds
        put(4'b0010, pat[7], 10);
        put(4'b0100, pat[8], 10);
        put(4'b1000, pat[10], 10);
        for (int k = 0; k < 10; k++) put(4'b0001, k[0] ? pat[5] : pat[6], 3);
        check("unsettled_cnt", 32'(acc_cnt), 32'd6);
        check("unsettled_valid", 32'(out_valid), 32'd0);
        put(4'b0001, pat[9], 8);
        put(4'b0000, 7'h00, 10);
        check("settled_cnt", 32'(acc_cnt), 32'd7);
        check("settled_dig", 32'(acc_dig), 32'hA879);

        // Multi-hot and zero strobes never capture
        put(4'b0010, pat[11], 10);
        put(4'b0100, pat[13], 10);
        put(4'b1000, pat[14], 10);
        put(4'b0011, pat[5], 20);
        check("multihot_cnt", 32'(acc_cnt), 32'd7);
        check("multihot_valid", 32'(out_valid), 32'd0);
        put(4'b0000, pat[5], 20);
        check("zerohot_cnt", 32'(acc_cnt), 32'd7);
        put(4'b0001, pat[12], 10);
        put(4'b0000, 7'h00, 10);
        check("strobe_cnt", 32'(acc_cnt), 32'd8);
        check("strobe_dig", 32'(acc_dig), 32'hEDBC);

        // Backpressure: latency, retention, overrun
        out_ready = 1'b0;
        put(4'b0001, pat[5], 10);
        put(4'b0010, pat[6], 10);
        put(4'b0100, pat[7], 10);
        put(4'b1000, pat[8], 6);
        check("latency_before", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_rise", 32'(out_valid), 32'd1);
        put(4'b0000, 7'h00, 10);
        check("hold_dig", 32'(digits), 32'h8765);
        check("hold_err", 32'(digit_err), 32'd0);
        put(4'b0001, pat[0], 10);
        put(4'b0010, pat[1], 10);
        put(4'b0100, pat[2], 10);
        put(4'b1000, pat[3], 10);
        put(4'b0000, 7'h00, 10);
        check("ovr_pulses", 32'(ov_cnt), 32'd1);
        check("ovr_valid", 32'(out_valid), 32'd1);
        check("ovr_dig", 32'(digits), 32'h8765);
        out_ready = 1'b1;
        @(negedge clk);
        check("ready_drop", 32'(out_valid), 32'd0);
        check("ready_cnt", 32'(acc_cnt), 32'd9);
        check("ready_dig", 32'(acc_dig), 32'h8765);
        put(4'b0000, 7'h00, 10);
        check("ready_nonew", 32'(acc_cnt), 32'd9);

        // Reset mid-frame with a strobe active
        out_ready = 1'b0;
        put(4'b0001, pat[1], 10);
        put(4'b0010, pat[2], 10);
        put(4'b0100, pat[3], 10);
        put(4'b1000, pat[4], 10);
        put(4'b0000, 7'h00, 10);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        put(4'b0001, pat[9], 10);
        put(4'b0010, pat[8], 10);
        put(4'b0100, pat[7], 3);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_digits", 32'(digits), 32'd0);
        check("mid_rst_err", 32'(digit_err), 32'd0);
        check("mid_rst_mask", 32'(dut.mask_q), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        put(4'b0100, pat[7], 10);
        put(4'b1000, pat[6], 10);
        put(4'b0000, 7'h00, 10);
        check("post_rst_partial", 32'(acc_cnt), 32'd9);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        put(4'b0001, pat[5], 10);
        put(4'b0010, pat[4], 10);
        put(4'b0000, 7'h00, 10);
        check("post_rst_cnt", 32'(acc_cnt), 32'd10);
        check("post_rst_dig", 32'(acc_dig), 32'h6745);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
